// File: rtl/mult_isoschedule_ctrl.sv
// Sequencing controller for the iso-schedule multiplication datapath.
// Accepts a job, pulses the operand load, walks the lane index with the
// product-register write enable, then holds a result-valid until it is taken.
module mult_isoschedule_ctrl #(
  parameter int unsigned DIM_A = 8,
  parameter int unsigned IDX_W = $clog2(DIM_A),
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [IDX_W:0]   start_len,
  input  logic             abort,
  output logic             load_en,
  output logic [IDX_W-1:0] mul_idx,
  output logic             wr_en,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] job_cnt
);

  localparam int unsigned LenW = IDX_W + 1;
  localparam logic [LenW-1:0] DimLen = LenW'(DIM_A);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LenW-1:0]  eff_len_q, eff_len_d;
  logic [CNT_W-1:0] job_cnt_q, job_cnt_d;

  logic [LenW-1:0]  req_len;
  logic [LenW-1:0]  last_idx;

  // Normalise the requested length: 0 and anything past DIM_A mean all lanes.
  always_comb begin
    req_len = start_len;
    if (start_len == '0 || start_len > DimLen) begin
      req_len = DimLen;
    end
    last_idx = eff_len_q - LenW'(1);
  end

  // Next-state, index, length and counter update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    eff_len_d = eff_len_q;
    job_cnt_d = job_cnt_q;
    unique case (state_q)
      StIdle: begin
        // abort wins over a simultaneous request
        if (start_valid && !abort) begin
          eff_len_d = req_len;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        idx_d   = '0;
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        if (abort) begin
          idx_d   = '0;
          state_d = StIdle;
        end else if ({1'b0, idx_q} == last_idx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StDone: begin
        // abort is deliberately ignored once all lanes are written
        if (out_ready) begin
          job_cnt_d = job_cnt_q + CNT_W'(1);
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; abort gates the enables combinationally.
  always_comb begin
    start_ready = (state_q == StIdle);
    load_en     = (state_q == StLoad) && !abort;
    wr_en       = (state_q == StRun) && !abort;
    mul_idx     = (state_q == StRun) ? idx_q : '0;
    busy        = (state_q != StIdle);
    out_valid   = (state_q == StDone);
    job_cnt     = job_cnt_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      eff_len_q <= '0;
      job_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      eff_len_q <= eff_len_d;
      job_cnt_q <= job_cnt_d;
    end
  end

endmodule

// File: doc/mult_isoschedule_ctrl.md
# mult_isoschedule_ctrl

Sequencing controller for the iso-schedule baseline multiplication datapath. It accepts a job over a valid/ready handshake and pulses the load enable for the input and weight registers. It then steps the multiplier element index through the active input lanes with the product-register write enable, and reports completion over a second valid/ready handshake. It replaces the free-running index counter, so the product register is written only for real jobs and the surrounding logic knows when a result is complete.

## Interface
Parameters:
- DIM_A, 8: number of input lanes; at least 2.
- IDX_W, $clog2(DIM_A) (3): width of the lane index.
- CNT_W, 8: width of the completed-job counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_valid  in  1  job request.
- start_ready  out  1  controller can accept a job.
- start_len  in  IDX_W+1  number of active lanes; 0 means DIM_A; values above DIM_A clamp to DIM_A.
- abort  in  1  cancel the job in flight.
- load_en  out  1  input/weight registers capture on the next edge.
- mul_idx  out  IDX_W  lane index for the multiplier and the product-register index.
- wr_en  out  1  product-register write enable.
- busy  out  1  state is not IDLE.
- out_valid  out  1  all lanes of the job have been written.
- out_ready  in  1  consumer accepts the result.
- job_cnt  out  CNT_W  count of completed jobs, wraps.

## Operation
- Four-state FSM: IDLE, LOAD, RUN, DONE. Outputs are decoded from registered state, the registered index and the registered length.
- In IDLE:
  - start_ready=1.
  - On start_valid & start_ready, latch eff_len (start_len after the 0 and clamp rules) and go to LOAD.
- In LOAD:
  - load_en=1 for exactly one cycle.
  - idx is cleared to 0; next state is RUN.
- In RUN:
  - wr_en=1 and mul_idx=idx.
  - idx increments by 1 each cycle.
  - When idx==eff_len-1, the write still happens that cycle; next state is DONE.
- In DONE:
  - out_valid=1, held until out_ready.
  - On out_valid & out_ready, job_cnt increments (wrapping 2^CNT_W-1 to 0) and the next state is IDLE.
- mul_idx=0 outside RUN. wr_en and load_en are never both high.
- abort behaviour by state:
  - LOAD or RUN: next state is IDLE; wr_en and load_en are gated low in the abort cycle; job_cnt is unchanged.
  - IDLE: abort has priority over start_valid, so no job is accepted in that cycle.
  - DONE: abort is ignored.
- start_valid outside IDLE is ignored (start_ready=0). The requester must hold start_valid and start_len stable until the handshake.
- out_valid, once asserted, must not drop until out_ready.

## Timing
- Reset (asynchronous, any state, including mid-job):
  - state=IDLE, idx=0, eff_len=0, job_cnt=0.
  - Outputs while in reset and after it: start_ready=1, load_en=0, wr_en=0, mul_idx=0, busy=0, out_valid=0.
  - A job in flight is discarded.
- Handshake accepted in cycle 0:
  - LOAD in cycle 1.
  - RUN in cycles 2..eff_len+1, with mul_idx = cycle-2.
  - out_valid first high in cycle eff_len+2.
- Minimum job period is eff_len+3 cycles (out_ready tied high). start_ready returns the cycle after the DONE handshake; there is no overlap of DONE and a new accept.
- Each stall cycle of out_ready extends DONE by one cycle.
- busy=1 from cycle 1 through the last DONE cycle.
- Lane index stays within IDX_W bits: the last written lane is eff_len-1, which is at most DIM_A-1.

## Test plan
- Basic full job: start_len=8, out_ready=1.
  - load_en high in cycle 1.
  - wr_en high in cycles 2–9 with mul_idx 0..7.
  - out_valid in cycle 10; job_cnt goes 0→1; start_ready high again in cycle 11.
- Length rules:
  - start_len=3 gives exactly 3 writes (idx 0,1,2), then out_valid in cycle 5.
  - start_len=0 and start_len=15 both give 8 writes.
- Backpressure: out_ready low for 5 cycles in DONE.
  - out_valid held 6 cycles, busy=1 throughout, start_ready=0 throughout.
  - A start_valid pulse during the stall is ignored; job_cnt increments once.
- Abort timing:
  - Abort in the RUN cycle with mul_idx=4: wr_en=0 that cycle, IDLE the next cycle, job_cnt unchanged.
  - Abort in LOAD: load_en=0.
  - Abort in DONE: no effect.
  - Abort together with start_valid in IDLE: not accepted.
- Reset mid-job: assert rst_n=0 during RUN at idx 5.
  - All outputs return to reset values immediately.
  - After release, a new start_len=2 job completes normally with job_cnt=1.
- Counter wrap: 256 back-to-back jobs with start_len=1.
  - job_cnt reads 255 then 0.
  - Each job takes 4 cycles from accept to DONE handshake.
